msrv32_imem_ahb_resp: RTL and testbench
=======================================

MSRV32_IMEM_AHB_RESP -- requirements
Module: msrv32_imem_ahb_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: instruction memory size in 32-bit words; power of two, 16 to 65536.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
REQ-003 Parameter WAIT_STATES, default 1: data-phase wait cycles per read, 0 to 15.
REQ-004 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_in  input  1  reset, synchronous and active-high.
REQ-006 hsel_in  input  1  responder select.
REQ-007 htrans_in  input  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 haddr_in  input  32  fetch byte address, driven by the core PC block.
REQ-009 hready_out  output  1  transfer complete / responder ready; drives the core's ahb_ready_in.
REQ-010 hrdata_out  output  32  instruction word.
REQ-011 hresp_out  output  1  0 OKAY, 1 ERROR.
REQ-012 ld_en_in  input  1  preload write strobe.
REQ-013 ld_addr_in  input  log2(DEPTH_WORDS)  preload word index.
REQ-014 ld_data_in  input  32  preload data.

Function
REQ-015 The block SHALL accept a transfer on any rising edge where hsel_in=1, htrans_in[1]=1 and hready_out=1; IDLE and BUSY SHALL be ignored with no state change.
REQ-016 On acceptance, the block SHALL register haddr_in; address inputs SHALL be ignored while hready_out=0.
REQ-017 The FSM SHALL have states IDLE, WAIT, ERR1, ERR2.
REQ-018 A transfer is in range when BASE_ADDR <= haddr_in < BASE_ADDR+4*DEPTH_WORDS, and aligned when haddr_in[1:0]=00.
REQ-019 An aligned, in-range transfer with WAIT_STATES=0 SHALL keep the FSM in IDLE and load hrdata_out with mem[index] on the accepting edge, giving hready_out=1 and hresp_out=0 in the next cycle.
REQ-020 An aligned, in-range transfer with WAIT_STATES=N>0 SHALL enter WAIT with a 4-bit counter loaded to N.
REQ-021 In WAIT, hready_out SHALL be 0 and the counter SHALL decrement each cycle; the edge on which the counter equals 1 SHALL load hrdata_out and return the FSM to IDLE.
REQ-022 For WAIT_STATES=N, the number of hready_out=0 cycles SHALL be exactly N, followed by one hready_out=1 cycle with valid data.
REQ-023 A misaligned or out-of-range transfer SHALL give a two-cycle ERROR response: ERR1 (hready_out=0, hresp_out=1), then ERR2 (hready_out=1, hresp_out=1), then IDLE; hrdata_out SHALL be unchanged.
REQ-024 ERROR SHALL take precedence over the wait-state count; no wait states SHALL be inserted before ERR1.
REQ-025 In IDLE and ERR2, hready_out SHALL be 1, so a new transfer may be accepted back-to-back in the completing cycle; in IDLE, hresp_out SHALL be 0.
REQ-026 hrdata_out SHALL hold its value between completed OKAY reads.
REQ-027 Word index SHALL be (haddr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
REQ-028 When ld_en_in=1, mem[ld_addr_in] SHALL be written on the edge, in any state.
REQ-029 If a preload write and a data load hit the same word on the same edge, hrdata_out SHALL receive the old contents.
REQ-030 Memory contents SHALL not be initialised or cleared by rst_in.

Reset
REQ-031 While rst_in=1 at an edge, the FSM SHALL go to IDLE and the counter to 0, with hready_out=1, hresp_out=0 and hrdata_out=32'h0000_0000 from the next cycle.
REQ-032 Reset during WAIT, ERR1 or ERR2 SHALL abort the transfer; no data or ERROR SHALL be presented afterwards.
REQ-033 Transfers presented while rst_in=1 SHALL not be accepted.
REQ-034 Preload writes SHALL still occur during reset.

Verification
REQ-035 WAIT_STATES=0; preload mem[0]=32'h0000_0013, mem[1]=32'h0010_0093; NONSEQ to 0x0 then SEQ to 0x4 back-to-back -> hready_out stays 1, and hrdata_out is 0x00000013 then 0x00100093 on consecutive cycles.
REQ-036 WAIT_STATES=3; NONSEQ to 0x8 -> hready_out=0 for exactly 3 cycles, then hready_out=1 with hrdata_out=mem[2] and hresp_out=0.
REQ-037 Read of 0x2 (misaligned) -> ERR1 then ERR2 (hresp_out=1, hready_out 0 then 1), hrdata_out unchanged; a NONSEQ to 0x0 in the ERR2 cycle completes OKAY.
REQ-038 DEPTH_WORDS=1024; read of 0x1000 -> ERROR response; read of 0xFFC -> OKAY with mem[1023].
REQ-039 WAIT_STATES=2; assert rst_in in the first WAIT cycle -> next cycle hready_out=1, hresp_out=0, hrdata_out=0; no data delivered for the aborted read.
REQ-040 Preload mem[5]=A, then on the completing edge of a read of 0x14 write mem[5]=B -> hrdata_out=A; a following read returns B.

Source files
------------

// File: rtl/msrv32_imem_ahb_resp.sv
// AHB-Lite instruction-memory responder: preloadable word RAM, programmable
// data-phase wait states, two-cycle ERROR for misaligned or out-of-range fetches.
module msrv32_imem_ahb_resp #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          hsel_in,
    input  logic [1:0]    htrans_in,
    input  logic [31:0]   haddr_in,
    output logic          hready_out,
    output logic [31:0]   hrdata_out,
    output logic          hresp_out,
    input  logic          ld_en_in,
    input  logic [AW-1:0] ld_addr_in,
    input  logic [31:0]   ld_data_in
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [31:0]   mem [DEPTH_WORDS];
    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;

    logic          accept;
    logic          aligned;
    logic          in_range;
    logic [AW-1:0] idx;

    // BASE_ADDR is aligned to the memory size, so range check reduces to a
    // tag compare and the word index is taken straight from the address bits.
    assign accept   = hsel_in && htrans_in[1] && hready_out;
    assign aligned  = (haddr_in[1:0] == 2'b00);
    assign in_range = (haddr_in[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign idx      = haddr_in[AW+1:2];

    // Preload port: independent of FSM and reset; a same-edge read sees old data.
    always_ff @(posedge clk_in) begin
        if (ld_en_in)
            mem[ld_addr_in] <= ld_data_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            hready_out <= 1'b1;
            hresp_out  <= 1'b0;
            hrdata_out <= '0;
        end else begin
            case (state)
                S_IDLE, S_ERR2: begin
                    state      <= S_IDLE;
                    hready_out <= 1'b1;
                    hresp_out  <= 1'b0;
                    if (accept) begin
                        if (!aligned || !in_range) begin
                            state      <= S_ERR1;
                            hready_out <= 1'b0;
                            hresp_out  <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            hrdata_out <= mem[idx];
                        end else begin
                            state      <= S_WAIT;
                            cnt        <= WS;
                            idx_q      <= idx;
                            hready_out <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        hrdata_out <= mem[idx_q];
                        state      <= S_IDLE;
                        hready_out <= 1'b1;
                    end
                end
                S_ERR1: begin
                    state      <= S_ERR2;
                    hready_out <= 1'b1;
                    hresp_out  <= 1'b1;
                end
                default: begin
                    state      <= S_IDLE;
                    hready_out <= 1'b1;
                    hresp_out  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msrv32_imem_ahb_resp.sv
// Scoreboard bench: three responders (0, 3 and 2 wait states); stimulus pushes
// cycle-stamped expected outputs, a negedge monitor pops and compares.
module tb_msrv32_imem_ahb_resp;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    typedef struct {
        int          at;
        int          inst;
        logic        rdy;
        logic        resp;
        logic [31:0] data;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsel    [3];
    logic [1:0]  htrans  [3];
    logic [31:0] haddr   [3];
    logic        ld_en   [3];
    logic [9:0]  ld_addr [3];
    logic [31:0] ld_data [3];
    logic        rdy     [3];
    logic        resp    [3];
    logic [31:0] rdata   [3];

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        msrv32_imem_ahb_resp #(
            .DEPTH_WORDS(1024),
            .BASE_ADDR  (32'h0000_0000),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2))
        ) u_dut (
            .clk_in    (clk),
            .rst_in    (rst),
            .hsel_in   (hsel[g]),
            .htrans_in (htrans[g]),
            .haddr_in  (haddr[g]),
            .hready_out(rdy[g]),
            .hrdata_out(rdata[g]),
            .hresp_out (resp[g]),
            .ld_en_in  (ld_en[g]),
            .ld_addr_in(ld_addr[g]),
            .ld_data_in(ld_data[g])
        );
    end

    // Monitor: compare every entry due this cycle; anything overdue is a miss.
    always @(negedge clk) begin
        for (int k = sbq.size() - 1; k >= 0; k--) begin
            if (sbq[k].at <= cyc) begin
                checks++;
                if (sbq[k].at != cyc || rdy[sbq[k].inst] !== sbq[k].rdy ||
                    resp[sbq[k].inst] !== sbq[k].resp || rdata[sbq[k].inst] !== sbq[k].data) begin
                    errors++;
                    $display("FAIL %s inst%0d cyc%0d (due %0d): got rdy=%b resp=%b data=%h, want rdy=%b resp=%b data=%h",
                             sbq[k].name, sbq[k].inst, cyc, sbq[k].at, rdy[sbq[k].inst],
                             resp[sbq[k].inst], rdata[sbq[k].inst], sbq[k].rdy, sbq[k].resp, sbq[k].data);
                end
                sbq.delete(k);
            end
        end
    end

    function automatic void push_exp(int at, int inst, logic r, logic e, logic [31:0] d, string name);
        exp_t x;
        x.at = at; x.inst = inst; x.rdy = r; x.resp = e; x.data = d; x.name = name;
        sbq.push_back(x);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(int i, logic s, logic [1:0] t, logic [31:0] a);
        hsel[i] = s; htrans[i] = t; haddr[i] = a;
    endtask

    task automatic pl(int i, int a, logic [31:0] d);
        ld_en[i] = 1'b1; ld_addr[i] = 10'(a); ld_data[i] = d;
        tick();
        ld_en[i] = 1'b0;
    endtask

    initial begin
        int c;
        int d;
        for (int i = 0; i < 3; i++) begin
            drv(i, 1'b0, T_IDLE, 32'h0);
            ld_en[i] = 1'b0; ld_addr[i] = '0; ld_data[i] = '0;
        end
        rst = 1'b1;
        tick();
        tick();
        c = cyc;
        for (int i = 0; i < 3; i++) push_exp(c, i, 1'b1, 1'b0, 32'h0, "reset");
        rst = 1'b0;

        pl(0, 0, 32'h0000_0013);
        pl(0, 1, 32'h0010_0093);
        pl(0, 1023, 32'hDEAD_BEEF);
        pl(1, 0, 32'h1111_1111);
        pl(1, 2, 32'h0020_8113);
        pl(2, 3, 32'hCAFE_F00D);

        // Zero wait states, back-to-back NONSEQ/SEQ
        drv(0, 1'b1, T_NSEQ, 32'h0);
        c = cyc;
        push_exp(c + 1, 0, 1'b1, 1'b0, 32'h0000_0013, "b2b0");
        tick();
        drv(0, 1'b1, T_SEQ, 32'h4);
        push_exp(c + 2, 0, 1'b1, 1'b0, 32'h0010_0093, "b2b1");
        tick();
        drv(0, 1'b0, T_IDLE, 32'h0);
        push_exp(c + 3, 0, 1'b1, 1'b0, 32'h0010_0093, "hold");
        tick();

        // BUSY, unselected and IDLE are ignored even on bad addresses
        drv(0, 1'b1, T_BUSY, 32'h2);
        c = cyc;
        push_exp(c + 1, 0, 1'b1, 1'b0, 32'h0010_0093, "busy");
        tick();
        drv(0, 1'b0, T_NSEQ, 32'h2);
        push_exp(c + 2, 0, 1'b1, 1'b0, 32'h0010_0093, "nosel");
        tick();
        drv(0, 1'b1, T_IDLE, 32'h1000);
        push_exp(c + 3, 0, 1'b1, 1'b0, 32'h0010_0093, "idle");
        tick();

        // Out of range, then last word
        drv(0, 1'b1, T_NSEQ, 32'h1000);
        c = cyc;
        push_exp(c + 1, 0, 1'b0, 1'b1, 32'h0010_0093, "oor1");
        push_exp(c + 2, 0, 1'b1, 1'b1, 32'h0010_0093, "oor2");
        push_exp(c + 3, 0, 1'b1, 1'b0, 32'h0010_0093, "oor3");
        push_exp(c + 4, 0, 1'b1, 1'b0, 32'hDEAD_BEEF, "last");
        tick();
        drv(0, 1'b0, T_IDLE, 32'h0);
        tick();
        tick();
        drv(0, 1'b1, T_NSEQ, 32'hFFC);
        tick();
        drv(0, 1'b0, T_IDLE, 32'h0);

        // Three wait states; address changes during wait must be ignored
        drv(1, 1'b1, T_NSEQ, 32'h8);
        c = cyc;
        for (int k = 1; k <= 3; k++) push_exp(c + k, 1, 1'b0, 1'b0, 32'h0, "ws3");
        push_exp(c + 4, 1, 1'b1, 1'b0, 32'h0020_8113, "ws3d");
        push_exp(c + 5, 1, 1'b1, 1'b0, 32'h0020_8113, "ws3h");
        tick();
        drv(1, 1'b1, T_NSEQ, 32'h2);
        tick();
        tick();
        drv(1, 1'b0, T_IDLE, 32'h0);
        tick();
        tick();
        tick();

        // Misaligned -> ERR1/ERR2 with no wait states; new fetch in ERR2
        drv(1, 1'b1, T_NSEQ, 32'h2);
        c = cyc;
        push_exp(c + 1, 1, 1'b0, 1'b1, 32'h0020_8113, "err1");
        push_exp(c + 2, 1, 1'b1, 1'b1, 32'h0020_8113, "err2");
        for (int k = 3; k <= 5; k++) push_exp(c + k, 1, 1'b0, 1'b0, 32'h0020_8113, "e2w");
        push_exp(c + 6, 1, 1'b1, 1'b0, 32'h1111_1111, "e2ok");
        tick();
        drv(1, 1'b0, T_IDLE, 32'h0);
        tick();
        drv(1, 1'b1, T_NSEQ, 32'h0);
        tick();
        drv(1, 1'b0, T_IDLE, 32'h0);
        for (int k = 0; k < 4; k++) tick();

        // Two wait states, then reset in first WAIT cycle
        drv(2, 1'b1, T_NSEQ, 32'hC);
        c = cyc;
        push_exp(c + 1, 2, 1'b0, 1'b0, 32'h0, "ws2");
        push_exp(c + 2, 2, 1'b0, 1'b0, 32'h0, "ws2");
        push_exp(c + 3, 2, 1'b1, 1'b0, 32'hCAFE_F00D, "ws2d");
        tick();
        drv(2, 1'b0, T_IDLE, 32'h0);
        tick();
        tick();
        drv(2, 1'b1, T_NSEQ, 32'hC);
        d = cyc;
        push_exp(d + 1, 2, 1'b0, 1'b0, 32'hCAFE_F00D, "rstw");
        push_exp(d + 2, 2, 1'b1, 1'b0, 32'h0, "rst0");
        push_exp(d + 3, 2, 1'b1, 1'b0, 32'h0, "abrt");
        push_exp(d + 4, 2, 1'b1, 1'b0, 32'h0, "abrt");
        tick();
        rst = 1'b1;
        drv(2, 1'b1, T_NSEQ, 32'h2);
        ld_en[0] = 1'b1; ld_addr[0] = 10'd6; ld_data[0] = 32'h0000_0066;
        tick();
        rst = 1'b0;
        ld_en[0] = 1'b0;
        drv(2, 1'b0, T_IDLE, 32'h0);
        tick();
        tick();
        tick();

        // Preload colliding with the completing read returns old data
        pl(0, 5, 32'hAAAA_0005);
        drv(0, 1'b1, T_NSEQ, 32'h14);
        ld_en[0] = 1'b1; ld_addr[0] = 10'd5; ld_data[0] = 32'hBBBB_0005;
        c = cyc;
        push_exp(c + 1, 0, 1'b1, 1'b0, 32'hAAAA_0005, "rdold");
        push_exp(c + 2, 0, 1'b1, 1'b0, 32'hBBBB_0005, "rdnew");
        push_exp(c + 3, 0, 1'b1, 1'b0, 32'h0000_0066, "plrst");
        tick();
        ld_en[0] = 1'b0;
        drv(0, 1'b1, T_NSEQ, 32'h14);
        tick();
        drv(0, 1'b1, T_NSEQ, 32'h18);
        tick();
        drv(0, 1'b0, T_IDLE, 32'h0);

        for (int k = 0; k < 20 && sbq.size() > 0; k++) tick();
        if (sbq.size() > 0) begin
            errors += sbq.size();
            $display("FAIL drain: got %0d pending entries, want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
